// File: rtl/bist_pattern_seq_if.sv
// ============================================================================
// Module      : bist_pattern_seq_if
// Description : Single-port memory bus between the BIST sequencer (master)
//               and the memory under test (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bist_pattern_seq_if #(
    parameter int AW = 4
) ();
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport master (
        output mem_cs,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/bist_pattern_seq.sv
// ============================================================================
// Module      : bist_pattern_seq
// Description : Three-mode BIST sequencer. For each toggle-generator mode it
//               fills the memory with a checkerboard of the mode's background
//               pattern, reads it back and compares, recording the first
//               failing address/mode in sticky registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_pattern_seq #(
    parameter int AW           = 4,
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    output logic [1:0]                pat_en,
    bist_pattern_seq_if.master        mem,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [AW-1:0]             fail_addr,
    output logic [1:0]                fail_mode
);

    localparam int            c_st_w        = 3;
    localparam logic [c_st_w-1:0] c_st_idle = 3'd0;
    localparam logic [c_st_w-1:0] c_st_write = 3'd1;
    localparam logic [c_st_w-1:0] c_st_read  = 3'd2;
    localparam logic [c_st_w-1:0] c_st_cmp   = 3'd3;
    localparam logic [c_st_w-1:0] c_st_done  = 3'd4;

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_addr_one  = AW'(1);

    // Even addresses get the background, odd addresses its complement.
    function automatic logic [7:0] pattern(input logic [1:0] m, input logic a0);
        logic [7:0] bg;
        case (m)
            2'b01:   bg = 8'h55;
            2'b10:   bg = 8'h0F;
            2'b11:   bg = 8'h33;
            default: bg = 8'h00;
        endcase
        return a0 ? ~bg : bg;
    endfunction

    logic [c_st_w-1:0] state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic [AW-1:0]     cmp_addr_q, cmp_addr_d;
    logic [1:0]        cmp_mode_q, cmp_mode_d;
    logic              fail_q, fail_d;
    logic [AW-1:0]     fail_addr_q, fail_addr_d;
    logic [1:0]        fail_mode_q, fail_mode_d;

    logic              w_last;
    logic              w_mismatch;
    logic              w_abort;

    // Read data lands one cycle after issue, so it is checked against the
    // address/mode that were on the bus in the previous cycle.
    assign w_last     = (addr_q == c_last_addr);
    assign w_mismatch = rd_vld_q && ((state_q == c_st_read) || (state_q == c_st_cmp)) &&
                        (mem.mem_rdata != pattern(cmp_mode_q, cmp_addr_q[0]));
    assign w_abort    = (STOP_ON_FAIL != 0) && w_mismatch;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= c_st_idle;
            mode_q      <= 2'b00;
            addr_q      <= '0;
            rd_vld_q    <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_mode_q  <= 2'b00;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_mode_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            rd_vld_q    <= rd_vld_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_mode_q  <= cmp_mode_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_mode_q <= fail_mode_d;
        end
    end

    // Next-state logic: write pass, read pass, final compare, next mode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:  if (start) state_d = c_st_write;
            c_st_write: if (w_last) state_d = c_st_read;
            c_st_read: begin
                if (w_abort)     state_d = c_st_done;
                else if (w_last) state_d = c_st_cmp;
            end
            c_st_cmp:   state_d = (w_abort || (mode_q == 2'b11)) ? c_st_done : c_st_write;
            c_st_done:  state_d = c_st_idle;
            default:    state_d = c_st_idle;
        endcase
    end

    // Address/mode counters, compare pipeline and sticky failure capture.
    always_comb begin
        mode_d      = mode_q;
        addr_d      = addr_q;
        rd_vld_d    = (state_q == c_st_read);
        cmp_addr_d  = addr_q;
        cmp_mode_d  = mode_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_mode_d = fail_mode_q;
        case (state_q)
            c_st_idle: begin
                if (start) begin
                    mode_d = 2'b01;
                    addr_d = '0;
                end
            end
            c_st_write: addr_d = w_last ? '0 : addr_q + c_addr_one;
            c_st_read:  addr_d = (w_last || w_abort) ? '0 : addr_q + c_addr_one;
            c_st_cmp: begin
                addr_d = '0;
                if (!w_abort && (mode_q != 2'b11)) mode_d = mode_q + 2'b01;
            end
            default: addr_d = '0;
        endcase
        if ((state_q == c_st_idle) && start) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_mode_d = 2'b00;
        end else if (w_mismatch && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr_q;
            fail_mode_d = cmp_mode_q;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        pat_en        = 2'b00;
        mem.mem_cs    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = 8'h00;
        case (state_q)
            c_st_write: begin
                busy          = 1'b1;
                pat_en        = mode_q;
                mem.mem_cs    = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_wdata = pattern(mode_q, addr_q[0]);
            end
            c_st_read: begin
                busy       = 1'b1;
                pat_en     = mode_q;
                mem.mem_cs = 1'b1;
            end
            c_st_cmp: begin
                busy   = 1'b1;
                pat_en = mode_q;
            end
            c_st_done: done = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_addr = addr_q;
    assign fail         = fail_q;
    assign fail_addr    = fail_addr_q;
    assign fail_mode    = fail_mode_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_pattern_seq.sv
// ============================================================================
// Module      : tb_bist_pattern_seq
// Description : Directed self-checking bench for bist_pattern_seq with a
//               behavioural memory per DUT and injectable read faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_pattern_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       start0, start1;
    logic [1:0] pat_en0, pat_en1;
    logic       busy0, done0, fail0, busy1, done1, fail1;
    logic [3:0] fail_addr0, fail_addr1;
    logic [1:0] fail_mode0, fail_mode1;

    bist_pattern_seq_if #(.AW(4)) if0 ();
    bist_pattern_seq_if #(.AW(4)) if1 ();

    bist_pattern_seq #(.AW(4), .DEPTH(16), .STOP_ON_FAIL(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .pat_en(pat_en0), .mem(if0),
        .busy(busy0), .done(done0), .fail(fail0),
        .fail_addr(fail_addr0), .fail_mode(fail_mode0)
    );

    bist_pattern_seq #(.AW(4), .DEPTH(16), .STOP_ON_FAIL(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .pat_en(pat_en1), .mem(if1),
        .busy(busy1), .done(done1), .fail(fail1),
        .fail_addr(fail_addr1), .fail_mode(fail_mode1)
    );

    // Fault injection: a read of (addr, mode) returns stored data with bit 0 inverted.
    logic       fa_en, fb_en;
    logic [3:0] fa_addr, fb_addr;
    logic [1:0] fa_mode, fb_mode;

    function automatic logic [7:0] corrupt(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m);
        logic [7:0] r;
        r = d;
        if (fa_en && (a == fa_addr) && (m == fa_mode)) r = r ^ 8'h01;
        if (fb_en && (a == fb_addr) && (m == fb_mode)) r = r ^ 8'h01;
        return r;
    endfunction

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [7:0] rdata0, rdata1;
    logic [7:0] wr_seen [4][2];

    assign if0.mem_rdata = rdata0;
    assign if1.mem_rdata = rdata1;

    // Memory models: synchronous write, registered read (1-cycle latency).
    always @(posedge clk) begin
        if (if0.mem_cs && if0.mem_we) begin
            mem0[if0.mem_addr] <= if0.mem_wdata;
            if (if0.mem_addr < 4'd2) wr_seen[pat_en0][if0.mem_addr[0]] <= if0.mem_wdata;
        end
        if (if0.mem_cs && !if0.mem_we) rdata0 <= corrupt(mem0[if0.mem_addr], if0.mem_addr, pat_en0);
        if (if1.mem_cs && if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
        if (if1.mem_cs && !if1.mem_we) rdata1 <= corrupt(mem1[if1.mem_addr], if1.mem_addr, pat_en1);
    end

    logic [24:0] outs0;
    assign outs0 = {pat_en0, if0.mem_cs, if0.mem_we, if0.mem_addr, if0.mem_wdata,
                    busy0, done0, fail0, fail_addr0, fail_mode0};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the first busy sample; returns on the negedge showing done.
    task automatic run_wait0(output int nb, output logic gd);
        nb = 0; gd = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done0) begin gd = 1'b1; break; end
            if (busy0) nb++;
            @(negedge clk);
        end
    endtask

    task automatic run_wait1(output int nb, output logic gd);
        nb = 0; gd = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done1) begin gd = 1'b1; break; end
            if (busy1) nb++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   nb;
    logic gd;
    int   cnt;
    logic found;

    initial begin
        rstn = 1'b0; start0 = 1'b0; start1 = 1'b0;
        fa_en = 1'b0; fb_en = 1'b0;
        fa_addr = 4'd0; fa_mode = 2'b00; fb_addr = 4'd0; fb_mode = 2'b00;
        rdata0 = 8'h00; rdata1 = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs0), 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: clean run
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        run_wait0(nb, gd);
        check("t1_done", 32'(gd), 32'h1);
        check("t1_busy_cycles", 32'(nb), 32'd99);
        check("t1_fail", 32'(fail0), 32'h0);
        check("t1_w_m1_a0", 32'(wr_seen[1][0]), 32'h55);
        check("t1_w_m1_a1", 32'(wr_seen[1][1]), 32'hAA);
        check("t1_w_m2_a0", 32'(wr_seen[2][0]), 32'h0F);
        check("t1_w_m2_a1", 32'(wr_seen[2][1]), 32'hF0);
        check("t1_w_m3_a0", 32'(wr_seen[3][0]), 32'h33);
        check("t1_w_m3_a1", 32'(wr_seen[3][1]), 32'hCC);
        check("t1_mem15", 32'(mem0[15]), 32'hCC);
        @(negedge clk);
        check("t1_done_pulse", 32'({done0, busy0}), 32'h0);

        // 2: single fault, run continues to the end
        fa_en = 1'b1; fa_addr = 4'd5; fa_mode = 2'b10;
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        run_wait0(nb, gd);
        check("t2_done", 32'(gd), 32'h1);
        check("t2_busy_cycles", 32'(nb), 32'd99);
        check("t2_fail", 32'(fail0), 32'h1);
        check("t2_fail_addr", 32'(fail_addr0), 32'h5);
        check("t2_fail_mode", 32'(fail_mode0), 32'h2);

        // 3: same fault, stop-on-fail instance: 33 + 16 + 7 busy cycles
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        run_wait1(nb, gd);
        check("t3_done", 32'(gd), 32'h1);
        check("t3_busy_cycles", 32'(nb), 32'd56);
        check("t3_fail", 32'({fail1, fail_addr1, fail_mode1}), 32'({1'b1, 4'd5, 2'b10}));
        check("t3_done_outs", 32'({pat_en1, if1.mem_cs, busy1}), 32'h0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if1.mem_cs || done1) cnt++;
        end
        check("t3_no_access_after", 32'(cnt), 32'd0);

        // 4: two faults, the first one is kept
        fa_addr = 4'd2; fa_mode = 2'b01;
        fb_en = 1'b1; fb_addr = 4'd9; fb_mode = 2'b11;
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        run_wait0(nb, gd);
        check("t4_done", 32'(gd), 32'h1);
        check("t4_fail", 32'(fail0), 32'h1);
        check("t4_fail_addr", 32'(fail_addr0), 32'h2);
        check("t4_fail_mode", 32'(fail_mode0), 32'h1);
        fa_en = 1'b0; fb_en = 1'b0;
        @(negedge clk);

        // 5: reset during the mode-10 read pass
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pat_en0 == 2'b10 && if0.mem_cs && !if0.mem_we && if0.mem_addr == 4'd3) begin
                found = 1'b1; break;
            end
            @(negedge clk);
        end
        check("t5_reach_read", 32'(found), 32'h1);
        rstn = 1'b0;
        #1;
        check("t5_reset_outs", 32'(outs0), 32'h0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rstn = 1'b1;
            if (done0 || busy0) cnt++;
        end
        check("t5_no_done", 32'(cnt), 32'd0);
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        run_wait0(nb, gd);
        check("t5_rerun_done", 32'(gd), 32'h1);
        check("t5_rerun_busy", 32'(nb), 32'd99);
        check("t5_rerun_fail", 32'(fail0), 32'h0);
        @(negedge clk);

        // 6: start held high -> back-to-back runs, fail cleared at each accept
        fa_en = 1'b1; fa_addr = 4'd5; fa_mode = 2'b10;
        start0 = 1'b1; @(negedge clk);
        run_wait0(nb, gd);
        check("t6_run1_busy", 32'(nb), 32'd99);
        check("t6_run1_fail", 32'(fail0), 32'h1);
        fa_en = 1'b0;
        @(negedge clk);
        check("t6_idle_gap", 32'({busy0, done0}), 32'h0);
        @(negedge clk);
        check("t6_restart", 32'({busy0, fail0}), 32'h2);
        run_wait0(nb, gd);
        start0 = 1'b0;
        check("t6_run2_done", 32'(gd), 32'h1);
        check("t6_run2_busy", 32'(nb), 32'd99);
        check("t6_run2_fail", 32'(fail0), 32'h0);
        repeat (2) @(negedge clk);
        check("t6_stopped", 32'({busy0, done0}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
